// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Multi-cycle responder for the pipeline's data-memory port. Each read or
// write request is sampled in IDLE and held in BUSY for LATENCY cycles. It is
// then answered with a one-cycle memReady strobe and registered read data.
// A stall is raised back to the pipeline until the access completes. As a
// bench aid it tracks the running signed maximum of committed writes, along
// with the word index of that maximum.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      number of BUSY cycles per access (>= 1)
//
// Ports
//   clk               in   single clock, rising edge
//   rst               in   asynchronous, active-low reset
//   dataMemAddress    in   byte address; word index = addr[31:2]
//   dataMemWriteData  in   write data
//   dataMemRead       in   read request level
//   dataMemWrite      in   write request level (wins over read)
//   dataMemReadData   out  registered read data, valid while memReady
//   memReady          out  one-cycle completion strobe
//   memStall          out  combinational stall to the pipeline
//   max               out  running signed maximum of committed write data
//   maxIndex          out  word index of max, zero-extended
//   maxValid          out  at least one in-range write has committed
//   errFlag           out  sticky out-of-range access flag

module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dataMemAddress,
   input  logic [31:0] dataMemWriteData,
   input  logic        dataMemRead,
   input  logic        dataMemWrite,
   output logic [31:0] dataMemReadData,
   output logic        memReady,
   output logic        memStall,
   output logic [31:0] max,
   output logic [31:0] maxIndex,
   output logic        maxValid,
   output logic        errFlag
);

   localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
   localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [CntW-1:0] CntLoad  = CntW'(LATENCY - 1);
   localparam logic [29:0]     DepthLim = 30'(DEPTH_WORDS);
   localparam logic [31:0]     MaxReset = 32'h8000_0000;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } state_e;

   state_e state_q, state_d;

   // Latched request. Address bits [1:0] are never used.
   logic [29:0]     word_idx_q;
   logic [31:0]     wdata_q;
   logic            is_write_q;
   logic [CntW-1:0] cnt_q;

   logic [31:0] rdata_q;
   logic [31:0] max_q;
   logic [31:0] max_idx_q;
   logic        max_valid_q;
   logic        err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic            req;
   logic            sample;
   logic            commit;
   logic            in_range;
   logic [IdxW-1:0] mem_idx;
   logic [31:0]     mem_rdata;
   logic            wr_commit;
   logic            max_update;
   logic            unused_addr_lsb;

   assign unused_addr_lsb = ^dataMemAddress[1:0];

   assign req      = dataMemRead | dataMemWrite;
   assign sample   = (state_q == StIdle) && req;
   // The commit edge is the last BUSY edge; everything the access does
   // happens on that edge.
   assign commit   = (state_q == StBusy) && (cnt_q == '0);
   assign in_range = word_idx_q < DepthLim;
   assign mem_idx  = word_idx_q[IdxW-1:0];
   assign mem_rdata = mem[mem_idx];

   assign wr_commit  = commit && is_write_q && in_range;
   // Strictly greater keeps the earlier index on ties.
   assign max_update = wr_commit &&
                       (!max_valid_q || ($signed(wdata_q) > $signed(max_q)));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == '0) begin
               state_d = StResp;
            end
         end
         // A request present in RESP is not sampled; it is seen again in IDLE.
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      memReady = 1'b0;
      memStall = 1'b0;
      if (state_q == StResp) begin
         memReady = 1'b1;
      end else begin
         memStall = req;
      end
   end

   // ------------------------------------------------------------------
   // Request latch and latency counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_idx_q <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         cnt_q      <= '0;
      end else if (sample) begin
         word_idx_q <= dataMemAddress[31:2];
         wdata_q    <= dataMemWriteData;
         // Read and write together behave as a write.
         is_write_q <= dataMemWrite;
         cnt_q      <= CntLoad;
      end else if ((state_q == StBusy) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Storage array. Not reset; a reset mid-access leaves the FSM outside
   // BUSY, so the pending write can never commit.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         mem[mem_idx] <= wdata_q;
      end
   end

   // ------------------------------------------------------------------
   // Response data and sticky error
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (commit) begin
         if (is_write_q) begin
            rdata_q <= wdata_q;
         end else if (in_range) begin
            rdata_q <= mem_rdata;
         end else begin
            rdata_q <= '0;
         end
         if (!in_range) begin
            err_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Running signed maximum over committed in-range writes
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_q       <= MaxReset;
         max_idx_q   <= '0;
         max_valid_q <= 1'b0;
      end else if (max_update) begin
         max_q       <= wdata_q;
         max_idx_q   <= 32'(mem_idx);
         max_valid_q <= 1'b1;
      end
   end

   assign dataMemReadData = rdata_q;
   assign max             = max_q;
   assign maxIndex        = max_idx_q;
   assign maxValid        = max_valid_q;
   assign errFlag         = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=3). A table of
// single accesses, each with hand-computed read data and max/error state,
// is followed by two hand-written sequences: a reset in the middle of BUSY,
// and a request held continuously across back-to-back accesses.

module tb_data_mem_responder;

   localparam int unsigned Depth = 256;
   localparam int unsigned Lat   = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] dataMemAddress   = '0;
   logic [31:0] dataMemWriteData = '0;
   logic        dataMemRead      = 1'b0;
   logic        dataMemWrite     = 1'b0;
   logic [31:0] dataMemReadData;
   logic        memReady;
   logic        memStall;
   logic [31:0] max;
   logic [31:0] maxIndex;
   logic        maxValid;
   logic        errFlag;

   int checks = 0;
   int errors = 0;

   data_mem_responder #(
      .DEPTH_WORDS (Depth),
      .LATENCY     (Lat)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .dataMemAddress   (dataMemAddress),
      .dataMemWriteData (dataMemWriteData),
      .dataMemRead      (dataMemRead),
      .dataMemWrite     (dataMemWrite),
      .dataMemReadData  (dataMemReadData),
      .memReady         (memReady),
      .memStall         (memStall),
      .max              (max),
      .maxIndex         (maxIndex),
      .maxValid         (maxValid),
      .errFlag          (errFlag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_before;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [31:0] exp_max;
      logic [31:0] exp_idx;
      logic        exp_valid;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rb, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] er, input logic [31:0] em,
                               input logic [31:0] ei, input logic ev, input logic ee);
      vec_t v;
      v.rst_before = rb;  v.rd = rd;  v.wr = wr;  v.addr = addr;  v.wdata = wd;
      v.exp_rdata = er;  v.exp_max = em;  v.exp_idx = ei;
      v.exp_valid = ev;  v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk1({tag, "_ready"}, memReady, 1'b0);
      chk1({tag, "_stall"}, memStall, 1'b0);
      chk({tag, "_rdata"}, dataMemReadData, 32'h0);
      chk({tag, "_max"}, max, 32'h8000_0000);
      chk({tag, "_maxidx"}, maxIndex, 32'h0);
      chk1({tag, "_maxvalid"}, maxValid, 1'b0);
      chk1({tag, "_err"}, errFlag, 1'b0);
   endtask

   // Called at negedge+1; returns at negedge+1.
   task automatic do_reset(input string tag);
      dataMemRead  = 1'b0;
      dataMemWrite = 1'b0;
      rst = 1'b0;
      #1;
      chk_reset_vals(tag);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
   endtask

   // One complete access: drive, wait (bounded) for memReady, check latency,
   // stall length, strobe width and read data, then drop the request.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata);
      int  stalls;
      bit  seen;
      dataMemRead      = rd;
      dataMemWrite     = wr;
      dataMemAddress   = addr;
      dataMemWriteData = wd;
      stalls = 0;
      seen   = 1'b0;
      for (int k = 0; k <= 4 * Lat + 8; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (memReady) begin
            seen = 1'b1;
            chk({tag, "_latency"}, k, Lat + 1);
            chk1({tag, "_stall_in_resp"}, memStall, 1'b0);
            chk({tag, "_rdata"}, dataMemReadData, exp_rdata);
            break;
         end
         if (memStall) stalls++;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: memReady not seen, expected after %0d edges", tag, Lat + 1);
      end
      chk({tag, "_stall_cycles"}, stalls, Lat + 1);
      dataMemRead  = 1'b0;
      dataMemWrite = 1'b0;
      @(negedge clk);
      #1;
      chk1({tag, "_ready_width"}, memReady, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //                rst   rd    wr    addr          wdata         exp_rdata     exp_max       idx     valid err
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h10,       32'hAA,       32'hAA,       32'hAA,       32'd4,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h12,       32'h0,        32'hAA,       32'hAA,       32'd4,   1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h4,        32'hFFFF_FFFB,32'hFFFF_FFFB,32'hFFFF_FFFB,32'd1,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h8,        32'h7,        32'h7,        32'h7,        32'd2,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hC,        32'h7,        32'h7,        32'h7,        32'd2,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h8,        32'hFFFF_FFFF,32'hFFFF_FFFF,32'h7,        32'd2,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h8,        32'h0,        32'hFFFF_FFFF,32'h7,        32'd2,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4,        32'h0,        32'hFFFF_FFFB,32'h7,        32'd2,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h400,      32'h1234,     32'h1234,     32'h7,        32'd2,   1'b1, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h400,      32'h0,        32'h0,        32'h7,        32'd2,   1'b1, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC,32'h0,        32'h0,        32'h7,        32'd2,   1'b1, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h24,       32'h55,       32'h55,       32'h55,       32'd9,   1'b1, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h24,       32'h0,        32'h55,       32'h55,       32'd9,   1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1C,       32'h8000_0000,32'h8000_0000,32'h8000_0000,32'd7,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h20,       32'h8000_0000,32'h8000_0000,32'h8000_0000,32'd7,   1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h3FC,      32'h100,      32'h100,      32'h100,      32'd255, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h3FC,      32'h0,        32'h100,      32'h100,      32'd255, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h50,       32'h11,       32'h11,       32'h100,      32'd255, 1'b1, 1'b0));

      @(negedge clk);
      #1;

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         if (vecs[i].rst_before) do_reset({tag, "_reset"});
         access(tag, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
         chk({tag, "_max"}, max, vecs[i].exp_max);
         chk({tag, "_maxidx"}, maxIndex, vecs[i].exp_idx);
         chk1({tag, "_maxvalid"}, maxValid, vecs[i].exp_valid);
         chk1({tag, "_err"}, errFlag, vecs[i].exp_err);
      end

      // Reset two cycles into a BUSY write of 0x99 over the 0x11 at index 20.
      dataMemWrite     = 1'b1;
      dataMemRead      = 1'b0;
      dataMemAddress   = 32'h50;
      dataMemWriteData = 32'h99;
      repeat (2) @(negedge clk);
      #1;
      chk1("midrst_busy_stall", memStall, 1'b1);
      rst          = 1'b0;
      dataMemWrite = 1'b0;
      #1;
      chk_reset_vals("midrst_async");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk1($sformatf("midrst_hold_ready%0d", k), memReady, 1'b0);
      end
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk1($sformatf("midrst_after_ready%0d", k), memReady, 1'b0);
      end
      access("midrst_read", 1'b1, 1'b0, 32'h50, 32'h0, 32'h11);
      chk("midrst_max", max, 32'h8000_0000);
      chk1("midrst_maxvalid", maxValid, 1'b0);

      // Read of index 9 held continuously: strobes at edges 4 and 9, stall
      // drops only in RESP. Dropped at edge 10, before the third sample.
      dataMemRead    = 1'b1;
      dataMemAddress = 32'h24;
      for (int k = 0; k <= 10; k++) begin
         logic exp_rdy;
         if (k > 0) @(negedge clk);
         #1;
         exp_rdy = (k == 4) || (k == 9);
         chk1($sformatf("held_ready%0d", k), memReady, exp_rdy);
         chk1($sformatf("held_stall%0d", k), memStall, !exp_rdy);
         if (exp_rdy) chk($sformatf("held_rdata%0d", k), dataMemReadData, 32'h55);
      end
      dataMemRead = 1'b0;
      @(negedge clk);
      #1;
      chk1("held_idle_ready", memReady, 1'b0);
      chk1("held_idle_stall", memStall, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle responder for the pipeline's data-memory port: it receives read/write requests driven by the processor (`dataMemAddress`, `dataMemWriteData`, `dataMemRead`, `dataMemWrite`) and answers each one after a fixed latency with a ready strobe and registered read data. It also raises a stall back to the pipeline until the access completes. It keeps a running signed maximum of all committed writes, plus the word index of that maximum, for bench checking. It replaces the zero-wait data memory when the multicycle core is tested against realistic memory latency.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words. Must be a power of two, ≥ 4.
- `LATENCY`, 3: number of BUSY cycles per access. Must be ≥ 1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: asynchronous, active-low.
- `dataMemAddress`  in  32  byte address. Bits [1:0] are ignored. Word index = addr[31:2].
- `dataMemWriteData`  in  32  write data.
- `dataMemRead`  in  1  read request level.
- `dataMemWrite`  in  1  write request level.
- `dataMemReadData`  out  32  registered read data. Valid while `memReady`=1.
- `memReady`  out  1  one-cycle completion strobe.
- `memStall`  out  1  combinational stall to the pipeline.
- `max`  out  32  running signed maximum of committed write data.
- `maxIndex`  out  32  word index of `max`, zero-extended.
- `maxValid`  out  1  at least one in-range write has committed.
- `errFlag`  out  1  sticky out-of-range access flag.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if `dataMemRead` or `dataMemWrite` is high at the edge:
  - latch the address, write data and operation;
  - load the counter with LATENCY−1;
  - go to BUSY.
- Both request signals high: treated as a write. The read data returned is the write data.
- BUSY: the counter decrements each edge. At the edge where the counter is 0, go to RESP and do the following on that same edge:
  - In-range write: store the word to the array.
  - Read: register `mem[index]` into `dataMemReadData`.
  - Write: register the write data into `dataMemReadData`.
- RESP: `memReady`=1 for exactly one cycle. Go to IDLE at the next edge unconditionally. A request present during RESP is not sampled.
- Request inputs that change during BUSY or RESP are ignored. The latched copy is used.
- Out of range: word index ≥ DEPTH_WORDS.
  - Read returns 0.
  - Write is dropped; the array and max are unchanged.
  - `errFlag` is set at the commit edge and stays set until reset.
- Max tracking, at the commit edge of an in-range write: if `maxValid`=0, or the signed write data > signed `max`, then `max`←data, `maxIndex`←index, `maxValid`←1.
  - Ties keep the earlier index.
  - Max is a running value over writes. Overwriting the max location with a smaller value does not lower it.
- `memStall` = (`dataMemRead`|`dataMemWrite`) & (state≠RESP).
- Array contents are not reset and are X until written. The bench must write before reading.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE;
  - `memReady`=0, `dataMemReadData`=0;
  - `max`=32'h8000_0000, `maxIndex`=0, `maxValid`=0;
  - `errFlag`=0.
- Reset mid-operation aborts the access. A pending write is not committed. `memReady` never pulses for that access.
- Latency: request sampled at edge E0; BUSY occupies cycles E0..E_LATENCY; `memReady` is high between E_LATENCY and E_LATENCY+1.
- The processor must hold its request until it sees `memReady`, and drop it (or present a new one) after E_LATENCY+1.
- Minimum request-to-request spacing is LATENCY+2 cycles. A new request held continuously is sampled at E_LATENCY+2.
- With LATENCY=1: E0 → BUSY, E1 → RESP (`memReady` high), E2 → IDLE.
- `memStall` is high from the cycle the request appears through the last BUSY cycle. It is low in RESP and whenever there is no request.

## Test plan
- Reset, then LATENCY=3: write 0x0000_00AA at addr 0x10. Expected: `memStall` high for 4 cycles; `memReady` exactly 1 cycle, 4 edges after sampling; `max`=0xAA, `maxIndex`=4, `maxValid`=1.
- Read addr 0x12 after that write. Expected: `dataMemReadData`=0xAA during `memReady` (low bits ignored); `max` unchanged.
- Signed max and ties:
  - write −5 at index 1, then 7 at index 2, then 7 at index 3. Expected: `max`=7, `maxIndex`=2.
  - then write −1 at index 2. Expected: `max` still 7.
- Out of range: write 0x1234 at byte addr 4·DEPTH_WORDS, then read the same address. Expected: read returns 0; `errFlag`=1 and stays 1; `max` unchanged.
- Simultaneous `dataMemRead`=`dataMemWrite`=1 with data 0x55 at index 9. Expected: array[9]=0x55; `dataMemReadData`=0x55 on `memReady`.
- Assert `rst`=0 two cycles into a BUSY write. Expected: `memReady` never pulses; a subsequent read of that address shows the old value; all outputs are at reset values immediately, without waiting for a clock edge.
